// File: rtl/acu_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : acu_load_sequencer
//  Purpose  : Write-side driver for the accumulator unit (ACU). Results from
//             the datapath arrive over a valid/ready handshake, are buffered
//             in a small FIFO, and are issued to the ACU as one-cycle clock
//             enable pulses with stable load data.
//
//  Build option:
//    ACU_LOAD_VERIFY_EN  defined   -> a CHECK state follows every write and
//                                     compares acu_out_val against the value
//                                     just written; mismatches set the sticky
//                                     verify_err flag (one write per 2 cycles).
//                        undefined -> WRITE chains back to back (one write per
//                                     cycle); verify_err is tied low and
//                                     clr_err / acu_out_val are ignored.
//
//  Ports:
//    clk          in   clock, rising edge
//    rstn         in   asynchronous reset, active HIGH
//    src_valid    in   producer has data on src_data
//    src_data     in   [SIZE]  value to load into the ACU
//    src_ready    out  FIFO can accept (count < DEPTH, low during reset)
//    hold         in   inhibits issuing new ACU writes
//    clr_err      in   synchronous clear of verify_err
//    acu_ce       out  ACU clock enable, registered one-cycle pulses
//    acu_in_val   out  [SIZE]  ACU load data, registered, holds last value
//    acu_out_val  in   [SIZE]  ACU output for read-back
//    count        out  [$clog2(DEPTH)+1]  FIFO occupancy
//    busy         out  FIFO not empty or FSM not idle
//    verify_err   out  sticky read-back mismatch flag
//
//  Revision : 1.0  initial release
// ============================================================================
module acu_load_sequencer #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     src_valid,
  input  logic [SIZE-1:0]          src_data,
  output logic                     src_ready,
  input  logic                     hold,
  input  logic                     clr_err,
  output logic                     acu_ce,
  output logic [SIZE-1:0]          acu_in_val,
  input  logic [SIZE-1:0]          acu_out_val,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     verify_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

`ifdef ACU_LOAD_VERIFY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
  } state_t;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SIZE-1:0]   mem_q [DEPTH];
  logic [SIZE-1:0]   mem_d [DEPTH];
  logic              acu_ce_q, acu_ce_d;
  logic [SIZE-1:0]   acu_in_val_q, acu_in_val_d;

  logic              push;
  logic              pop;
  logic              can_issue;
  logic              start_write;
  logic              mismatch;

  // Ready looks only at registered occupancy, so a pop in the same cycle
  // never frees a slot for a same-cycle push.
  assign src_ready = !rstn && (count_q < FULL_COUNT);
  assign push      = src_valid && src_ready;
  // hold is only consulted at the moment a new write would be launched.
  assign can_issue = (count_q != '0) && !hold;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    start_write  = 1'b0;
    mismatch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d     = WRITE;
          start_write = 1'b1;
        end
      end

      WRITE: begin
`ifdef ACU_LOAD_VERIFY_EN
        // The ACU loads on the edge that leaves WRITE; compare one cycle later.
        state_d = CHECK;
`else
        if (can_issue) begin
          start_write = 1'b1;
        end else begin
          state_d = IDLE;
        end
`endif
      end

`ifdef ACU_LOAD_VERIFY_EN
      CHECK: begin
        mismatch = (acu_out_val != acu_in_val_q);
        if (can_issue) begin
          state_d     = WRITE;
          start_write = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Launching a write pops the head and presents it with a one-cycle enable;
  // otherwise the load data keeps its last value.
  always_comb begin
    pop          = start_write;
    acu_ce_d     = start_write;
    acu_in_val_d = start_write ? mem_q[rd_ptr_q] : acu_in_val_q;
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = src_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_q        <= '{default: '0};
      acu_ce_q     <= 1'b0;
      acu_in_val_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
      acu_ce_q     <= acu_ce_d;
      acu_in_val_q <= acu_in_val_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read-back error flag
  // --------------------------------------------------------------------------
`ifdef ACU_LOAD_VERIFY_EN
  logic verify_err_q, verify_err_d;

  // Sticky; a mismatch in the same cycle as clr_err wins.
  always_comb begin
    verify_err_d = verify_err_q;
    if (clr_err) begin
      verify_err_d = 1'b0;
    end
    if (mismatch) begin
      verify_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      verify_err_q <= 1'b0;
    end else begin
      verify_err_q <= verify_err_d;
    end
  end

  assign verify_err = verify_err_q;
`else
  // Read-back inputs have no function in this build.
  logic unused_readback;
  assign unused_readback = ^{clr_err, acu_out_val, mismatch};
  assign verify_err      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign acu_ce     = acu_ce_q;
  assign acu_in_val = acu_in_val_q;
  assign count      = count_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule
`default_nettype wire
